// File: rtl/duck_pkg.sv
// Shared types and constants for the duck-hunt game blocks.
// Holds the round state encoding, the score width and the timebase constants.
package duck_pkg;

  localparam int SCORE_W           = 7;
  localparam int MS_PER_SEC        = 1000;
  localparam int PROD_TICKS_PER_MS = 65_000;

  // The encoding is exported directly to the HUD as round_state.
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_ARMED    = 2'd1,
    ST_RUNNING  = 2'd2,
    ST_FINISHED = 2'd3
  } round_state_t;

endpackage

// File: rtl/duck_timebase.sv
// Millisecond prescaler plus a 0..999 ms counter that produce ms and second ticks.
// Deasserting run clears both counters on the next edge.
module duck_timebase
  import duck_pkg::*;
#(
  parameter int TICKS_PER_MS = PROD_TICKS_PER_MS
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  output logic ms_tick,
  output logic sec_tick
);

  localparam int PW = (TICKS_PER_MS > 1) ? $clog2(TICKS_PER_MS) : 1;
  localparam int MW = $clog2(MS_PER_SEC);

  localparam logic [PW-1:0] PRESC_LAST = PW'(TICKS_PER_MS - 1);
  localparam logic [MW-1:0] MS_LAST    = MW'(MS_PER_SEC - 1);

  logic [PW-1:0] presc;
  logic [MW-1:0] ms_cnt;

  assign ms_tick  = run && (presc == PRESC_LAST);
  assign sec_tick = ms_tick && (ms_cnt == MS_LAST);

  always_ff @(posedge clk) begin
    if (rst || !run) begin
      presc  <= '0;
      ms_cnt <= '0;
    end else begin
      if (ms_tick) presc <= '0;
      else         presc <= presc + 1'b1;

      if (sec_tick)     ms_cnt <= '0;
      else if (ms_tick) ms_cnt <= ms_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/duck_round_ctrl.sv
// Round sequencer: arms and clears the game datapath, times the round, ends it on
// timeout or target score, and keeps the final and session high scores for the HUD.
module duck_round_ctrl
  import duck_pkg::*;
#(
  parameter int TICKS_PER_MS = PROD_TICKS_PER_MS,
  parameter int ROUND_TIME_S = 60,
  parameter int OVER_HOLD_S  = 5,
  parameter int TARGET_SCORE = 100
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [SCORE_W-1:0] score,
  output logic               game_rst,
  output logic               game_enable,
  output logic [1:0]         round_state,
  output logic [SCORE_W-1:0] time_left,
  output logic [SCORE_W-1:0] final_score,
  output logic [SCORE_W-1:0] high_score,
  output logic               game_won
);

  localparam logic [SCORE_W-1:0] ROUND_T   = SCORE_W'(ROUND_TIME_S);
  localparam logic [SCORE_W-1:0] HOLD_LAST = SCORE_W'(OVER_HOLD_S - 1);
  localparam logic [SCORE_W-1:0] TARGET    = SCORE_W'(TARGET_SCORE);

  round_state_t       state, state_next;
  logic               start_q, start_rise;
  logic               win, run;
  logic               ms_tick, sec_tick, sec_evt;
  logic               game_rst_d, game_enable_d;
  logic [SCORE_W-1:0] hold_cnt;

  assign start_rise  = start && !start_q;
  assign win         = (state == ST_RUNNING) && (score >= TARGET);
  // A win clears the timebase on its way into FINISHED; a timeout or hold expiry
  // lands on a counter wrap, so those edges leave the counters at zero already.
  assign run         = ((state == ST_RUNNING) && !win) || (state == ST_FINISHED);
  assign sec_evt     = sec_tick && ms_tick;
  assign round_state = state;

  duck_timebase #(
    .TICKS_PER_MS(TICKS_PER_MS)
  ) u_timebase (
    .clk     (clk),
    .rst     (rst),
    .run     (run),
    .ms_tick (ms_tick),
    .sec_tick(sec_tick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      start_q     <= 1'b0;
      game_rst    <= 1'b0;
      game_enable <= 1'b0;
    end else begin
      state       <= state_next;
      start_q     <= start;
      game_rst    <= game_rst_d;
      game_enable <= game_enable_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE:     if (start_rise) state_next = ST_ARMED;
      ST_ARMED:    if (!start) state_next = ST_RUNNING;
      ST_RUNNING: begin
        if (win)                                       state_next = ST_FINISHED;
        else if (sec_evt && (time_left == 7'd1))       state_next = ST_FINISHED;
      end
      ST_FINISHED: if (sec_evt && (hold_cnt == HOLD_LAST)) state_next = ST_IDLE;
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    game_rst_d    = (state == ST_IDLE) && start_rise;
    game_enable_d = (state_next == ST_RUNNING);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      time_left   <= ROUND_T;
      final_score <= '0;
      high_score  <= '0;
      game_won    <= 1'b0;
      hold_cnt    <= '0;
    end else begin
      if ((state == ST_ARMED) && (state_next == ST_RUNNING))
        time_left <= ROUND_T;
      else if ((state == ST_RUNNING) && !win && sec_evt && (time_left != '0))
        time_left <= time_left - 1'b1;

      if ((state == ST_RUNNING) && (state_next == ST_FINISHED)) begin
        final_score <= score;
        if (score > high_score) high_score <= score;
        game_won    <= win;
        hold_cnt    <= '0;
      end else if ((state == ST_FINISHED) && sec_evt) begin
        hold_cnt <= hold_cnt + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_duck_round_ctrl.sv
// Directed bench for duck_round_ctrl with a fast timebase (2 ticks/ms, 3 s rounds,
// 2 s game-over hold); inputs change and outputs are sampled 1 ns after each edge.
module tb_duck_round_ctrl;

  localparam int TPMS = 2;
  localparam int RT   = 3;
  localparam int OH   = 2;
  localparam int TGT  = 100;
  localparam int SEC  = TPMS * 1000;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [6:0] score = '0;
  logic       game_rst, game_enable, game_won;
  logic [1:0] round_state;
  logic [6:0] time_left, final_score, high_score;

  int n_tests = 0;
  int n_fail  = 0;

  duck_round_ctrl #(
    .TICKS_PER_MS(TPMS),
    .ROUND_TIME_S(RT),
    .OVER_HOLD_S (OH),
    .TARGET_SCORE(TGT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .score      (score),
    .game_rst   (game_rst),
    .game_enable(game_enable),
    .round_state(round_state),
    .time_left  (time_left),
    .final_score(final_score),
    .high_score (high_score),
    .game_won   (game_won)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Click in menu for 4 cycles, release; returns on the edge that enters RUNNING.
  task automatic start_round();
    start = 1'b1;
    repeat (4) tick();
    start = 1'b0;
    tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    repeat (100) tick();
    n_tests++; if (round_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", round_state); end
    n_tests++; if (game_enable !== 1'b0) begin n_fail++; $display("FAIL reset_enable: got %0b expected 0", game_enable); end
    n_tests++; if (game_rst !== 1'b0) begin n_fail++; $display("FAIL reset_game_rst: got %0b expected 0", game_rst); end
    n_tests++; if (time_left !== 7'(RT)) begin n_fail++; $display("FAIL reset_time_left: got %0d expected %0d", time_left, RT); end
    n_tests++; if (final_score !== 7'd0) begin n_fail++; $display("FAIL reset_final: got %0d expected 0", final_score); end
    n_tests++; if (high_score !== 7'd0) begin n_fail++; $display("FAIL reset_high: got %0d expected 0", high_score); end
    n_tests++; if (game_won !== 1'b0) begin n_fail++; $display("FAIL reset_won: got %0b expected 0", game_won); end
  endtask

  task automatic test_timeout();
    score = 7'd37;
    start = 1'b1;
    tick();
    n_tests++; if (game_rst !== 1'b1 || round_state !== 2'd1) begin n_fail++; $display("FAIL arm_pulse: got rst=%0b state=%0d expected rst=1 state=1", game_rst, round_state); end
    tick();
    n_tests++; if (game_rst !== 1'b0 || round_state !== 2'd1) begin n_fail++; $display("FAIL arm_pulse_end: got rst=%0b state=%0d expected rst=0 state=1", game_rst, round_state); end
    repeat (2) tick();
    n_tests++; if (game_enable !== 1'b0) begin n_fail++; $display("FAIL armed_enable: got %0b expected 0", game_enable); end
    start = 1'b0;
    tick();
    n_tests++; if (round_state !== 2'd2 || game_enable !== 1'b1 || time_left !== 7'(RT)) begin n_fail++; $display("FAIL run_entry: got state=%0d en=%0b tl=%0d expected 2 1 %0d", round_state, game_enable, time_left, RT); end
    repeat (SEC - 1) tick();
    n_tests++; if (time_left !== 7'(RT)) begin n_fail++; $display("FAIL first_dec_early: got %0d expected %0d", time_left, RT); end
    tick();
    n_tests++; if (time_left !== 7'(RT - 1)) begin n_fail++; $display("FAIL first_dec: got %0d expected %0d", time_left, RT - 1); end
    repeat ((RT - 1) * SEC - 1) tick();
    n_tests++; if (round_state !== 2'd2 || game_enable !== 1'b1 || time_left !== 7'd1) begin n_fail++; $display("FAIL pre_timeout: got state=%0d en=%0b tl=%0d expected 2 1 1", round_state, game_enable, time_left); end
    tick();
    n_tests++; if (round_state !== 2'd3 || game_enable !== 1'b0 || time_left !== 7'd0) begin n_fail++; $display("FAIL timeout: got state=%0d en=%0b tl=%0d expected 3 0 0", round_state, game_enable, time_left); end
    n_tests++; if (game_won !== 1'b0 || final_score !== 7'd37 || high_score !== 7'd37) begin n_fail++; $display("FAIL timeout_scores: got won=%0b final=%0d high=%0d expected 0 37 37", game_won, final_score, high_score); end
  endtask

  // Entered right on the FINISHED entry edge of the previous round.
  task automatic test_finished_hold();
    bit saw_bad = 1'b0;
    score = 7'd50;
    for (int i = 0; i < OH * SEC - 10; i++) begin
      start = ~start;
      tick();
      if (game_rst !== 1'b0 || round_state !== 2'd3) saw_bad = 1'b1;
    end
    start = 1'b0;
    n_tests++; if (saw_bad) begin n_fail++; $display("FAIL hold_hammer: got rst pulse or early exit, expected FINISHED with no game_rst"); end
    repeat (9) tick();
    n_tests++; if (round_state !== 2'd3 || final_score !== 7'd37) begin n_fail++; $display("FAIL hold_end_early: got state=%0d final=%0d expected 3 37", round_state, final_score); end
    tick();
    n_tests++; if (round_state !== 2'd0 || game_rst !== 1'b0) begin n_fail++; $display("FAIL hold_exit: got state=%0d rst=%0b expected 0 0", round_state, game_rst); end
    n_tests++; if (final_score !== 7'd37 || high_score !== 7'd37 || game_won !== 1'b0) begin n_fail++; $display("FAIL idle_keeps: got final=%0d high=%0d won=%0b expected 37 37 0", final_score, high_score, game_won); end
  endtask

  task automatic test_high_score();
    int ends[3] = '{40, 25, 40};
    for (int r = 0; r < 3; r++) begin
      score = 7'd0;
      start_round();
      score = 7'(ends[r]);
      repeat (RT * SEC) tick();
      n_tests++; if (round_state !== 2'd3 || final_score !== 7'(ends[r]) || high_score !== 7'd40) begin n_fail++; $display("FAIL high_round%0d: got state=%0d final=%0d high=%0d expected 3 %0d 40", r, round_state, final_score, high_score, ends[r]); end
      repeat (OH * SEC) tick();
      n_tests++; if (round_state !== 2'd0) begin n_fail++; $display("FAIL high_idle%0d: got %0d expected 0", r, round_state); end
    end
  endtask

  task automatic test_win();
    score = 7'd0;
    start_round();
    repeat (500) tick();
    score = 7'd100;
    n_tests++; if (round_state !== 2'd2) begin n_fail++; $display("FAIL win_pre: got %0d expected 2", round_state); end
    tick();
    n_tests++; if (round_state !== 2'd3 || game_enable !== 1'b0 || game_won !== 1'b1) begin n_fail++; $display("FAIL win: got state=%0d en=%0b won=%0b expected 3 0 1", round_state, game_enable, game_won); end
    n_tests++; if (final_score !== 7'd100 || high_score !== 7'd100) begin n_fail++; $display("FAIL win_scores: got final=%0d high=%0d expected 100 100", final_score, high_score); end
    n_tests++; if (time_left !== 7'(RT)) begin n_fail++; $display("FAIL win_time_left: got %0d expected %0d", time_left, RT); end
    score = 7'd0;
    repeat (OH * SEC - 1) tick();
    n_tests++; if (round_state !== 2'd3) begin n_fail++; $display("FAIL win_hold_early: got %0d expected 3", round_state); end
    tick();
    n_tests++; if (round_state !== 2'd0 || game_won !== 1'b1) begin n_fail++; $display("FAIL win_hold_exit: got state=%0d won=%0b expected 0 1", round_state, game_won); end
  endtask

  task automatic test_win_on_last_tick();
    score = 7'd10;
    start_round();
    repeat (RT * SEC - 1) tick();
    score = 7'd100;
    tick();
    n_tests++; if (round_state !== 2'd3 || game_won !== 1'b1 || final_score !== 7'd100) begin n_fail++; $display("FAIL coincide: got state=%0d won=%0b final=%0d expected 3 1 100", round_state, game_won, final_score); end
    score = 7'd0;
    repeat (OH * SEC) tick();
    n_tests++; if (round_state !== 2'd0) begin n_fail++; $display("FAIL coincide_idle: got %0d expected 0", round_state); end
  endtask

  task automatic test_armed_hold();
    start = 1'b1;
    repeat (300) tick();
    n_tests++; if (round_state !== 2'd1 || game_enable !== 1'b0) begin n_fail++; $display("FAIL armed_hold: got state=%0d en=%0b expected 1 0", round_state, game_enable); end
    start = 1'b0;
    tick();
    n_tests++; if (round_state !== 2'd2) begin n_fail++; $display("FAIL armed_release: got %0d expected 2", round_state); end
  endtask

  task automatic test_rst_mid_run();
    score = 7'd60;
    repeat (SEC + 100) tick();
    rst = 1'b1;
    tick();
    n_tests++; if (round_state !== 2'd0 || game_enable !== 1'b0 || game_rst !== 1'b0) begin n_fail++; $display("FAIL rst_mid: got state=%0d en=%0b rst=%0b expected 0 0 0", round_state, game_enable, game_rst); end
    n_tests++; if (high_score !== 7'd0 || final_score !== 7'd0 || game_won !== 1'b0 || time_left !== 7'(RT)) begin n_fail++; $display("FAIL rst_mid_regs: got high=%0d final=%0d won=%0b tl=%0d expected 0 0 0 %0d", high_score, final_score, game_won, time_left, RT); end
    rst = 1'b0;
    score = 7'd0;
    tick();
  endtask

  initial begin
    test_reset();
    test_timeout();
    test_finished_hold();
    test_high_score();
    test_win();
    test_win_on_last_tick();
    test_armed_hold();
    test_rst_mid_run();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/duck_round_ctrl.md
# duck_round_ctrl

Round sequencer for the duck-hunt game. It sits between the mouse/menu inputs and `duck_game_logic`. It arms and clears the game datapath, enables it, times a fixed-length round, and ends the round on timeout or target score. It also latches the final score and keeps a session high score for the HUD overlay.

## Interface
Parameters:
- `TICKS_PER_MS`, default 65_000: clk cycles per millisecond; the bench uses small values.
- `ROUND_TIME_S`, default 60: round length in seconds, 1..127.
- `OVER_HOLD_S`, default 5: game-over screen hold in seconds, 1..127.
- `TARGET_SCORE`, default 100: score that ends the round as a win, 1..127.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  reset, synchronous, active-high.
- `start`  in  1  level; left mouse button while in menu.
- `score`  in  7  current score from `duck_game_logic`.
- `game_rst`  out  1  one-cycle clear pulse, ORed with `rst` at the `duck_game_logic` reset.
- `game_enable`  out  1  high throughout RUNNING.
- `round_state`  out  2  encoded state for the HUD.
- `time_left`  out  7  seconds remaining in round.
- `final_score`  out  7  score latched at round end.
- `high_score`  out  7  session maximum of `final_score`.
- `game_won`  out  1  last round ended by reaching `TARGET_SCORE`.

## Operation
- States (`round_state` encoding): IDLE=0, ARMED=1, RUNNING=2, FINISHED=3.
- `start` is registered once. `start_rise` = `start` & !`start_q`.
- IDLE:
  - `start_rise` → ARMED.
  - `game_rst` is pulsed in the same transition cycle.
- ARMED:
  - Waits for the `start` release so the menu click is not counted as a shot.
  - `start`==0 → RUNNING.
  - On entry to RUNNING: `time_left` loads `ROUND_TIME_S`; the prescaler and ms counter clear.
- RUNNING:
  - `game_enable`=1.
  - Each second tick decrements `time_left`.
  - `score` ≥ `TARGET_SCORE` → FINISHED with `game_won`=1.
  - A second tick while `time_left`==1 → FINISHED with `game_won`=0, and `time_left` becomes 0.
  - If both happen in the same cycle, the win takes priority.
- FINISHED:
  - On entry, `final_score` ← `score`. If `score` > `high_score`, then `high_score` ← `score`; ties leave it unchanged.
  - Counters clear on entry. The state holds `OVER_HOLD_S` seconds, then goes to IDLE.
  - `start` is ignored during the hold.
- IDLE does not change `final_score`, `high_score` or `game_won`. Only `rst` clears them.
- Timebase:
  - Prescaler counts 0..`TICKS_PER_MS`-1 and produces `ms_tick`.
  - ms counter counts 0..999 on `ms_tick` and produces `sec_tick`.
  - Both run only in RUNNING and FINISHED, and are held at 0 otherwise.
- Arithmetic:
  - `time_left` never wraps below 0.
  - All comparisons are unsigned 7-bit.

## Timing
- Reset values: state IDLE; `game_rst`=0, `game_enable`=0, `round_state`=0, `time_left`=`ROUND_TIME_S`, `final_score`=0, `high_score`=0, `game_won`=0; all counters 0.
- All outputs are registered. The state and outputs change on the clk edge after the causing input is sampled.
- `game_rst` latency: high exactly one cycle, in the cycle after the `start_rise` sample. The state shows ARMED in the same cycle.
- `game_enable`:
  - Rises in the cycle the state becomes RUNNING.
  - Falls in the cycle the state becomes FINISHED.
- First `time_left` decrement: exactly `TICKS_PER_MS`*1000 cycles after entering RUNNING.
- Timeout: FINISHED is entered `ROUND_TIME_S`*`TICKS_PER_MS`*1000 cycles after entering RUNNING.
- Hold: IDLE is re-entered `OVER_HOLD_S`*`TICKS_PER_MS`*1000 cycles after entering FINISHED.
- Reset mid-operation: `rst` returns to the reset values on the next edge from any state. `high_score` is lost.
- `start` held high through IDLE→ARMED stays in ARMED indefinitely. No timeout.

## Structure
- Shared package `duck_pkg`:
  - `round_state_t` enum.
  - Score width constant (7).
  - Timebase constants: `MS_PER_SEC`=1000 and the production `TICKS_PER_MS`.
- Sub-module `duck_timebase`:
  - Prescaler plus ms counter.
  - Ports: `clk`, `rst`, `run`, `ms_tick`, `sec_tick`; `run`=0 clears both counters.
  - Reused later by `duck_game_logic` for its delay counters.

## Test plan
- Reset, then idle 100 cycles → all outputs at reset values; `game_enable`=0; `time_left`=60.
- `TICKS_PER_MS`=2, `ROUND_TIME_S`=3; pulse `start` 4 cycles → `game_rst` is a single 1-cycle pulse; `game_enable` rises one cycle after `start` falls; it falls 6000 cycles later with `time_left`=0, `game_won`=0, `final_score`=`score`.
- Drive `score`=100 in RUNNING → FINISHED next edge; `game_won`=1; `high_score`=100.
- Two rounds with end scores 40 then 25 → `high_score` stays 40 and `final_score`=25. A third round ending at 40 leaves `high_score` 40.
- `score` reaches `TARGET_SCORE` in the same cycle as the last `sec_tick` → `game_won`=1.
- Hammer `start` during FINISHED → no `game_rst`; IDLE after exactly `OVER_HOLD_S`*`TICKS_PER_MS`*1000 cycles. Assert `rst` mid-RUNNING → IDLE next edge; `game_enable`=0; `high_score`=0.
